// File: rtl/ecc_arbiter_if.sv
// Handshake bundle between the two key requesters, the shared ECC
// point-multiplier core and the arbiter that shares it.
interface ecc_arbiter_if #(
  parameter int KW = 163,
  parameter int PW = 164
);
  logic          req0;
  logic          req1;
  logic [KW-1:0] k0;
  logic [KW-1:0] k1;
  logic          gnt0;
  logic          gnt1;
  logic          core_start;
  logic [KW-1:0] core_k;
  logic          core_done;
  logic [PW-1:0] core_x;
  logic [PW-1:0] core_y;
  logic [PW-1:0] res_x;
  logic [PW-1:0] res_y;
  logic          done0;
  logic          done1;
  logic          err;

  modport master (
    output req0, req1, k0, k1,
    output core_done, core_x, core_y,
    input  gnt0, gnt1, core_start, core_k,
    input  res_x, res_y, done0, done1, err
  );

  modport slave (
    input  req0, req1, k0, k1,
    input  core_done, core_x, core_y,
    output gnt0, gnt1, core_start, core_k,
    output res_x, res_y, done0, done1, err
  );
endinterface

// File: rtl/ecc_arbiter.sv
// Round-robin arbiter sharing one ECC point-multiplier core between
// public-key and session-key requesters, with a RUN-cycle timeout.
module ecc_arbiter #(
  parameter int KW      = 163,
  parameter int PW      = 164,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          n_rst,
  ecc_arbiter_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    ABORT
  } state_t;

  state_t        state;
  state_t        nxt;
  logic          last;
  logic          sel;
  logic          pick;
  logic          busy;
  logic [CW-1:0] cnt;
  logic [KW-1:0] k_q;
  logic [PW-1:0] rx;
  logic [PW-1:0] ry;

  // On a tie the requester not served last wins.
  assign pick = (bus.req0 && bus.req1) ? ~last : bus.req1;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) nxt = RUN;
      end
      RUN: begin
        if (bus.core_done)  nxt = DONE;
        else if (cnt == CMAX) nxt = ABORT;
      end
      DONE:  nxt = IDLE;
      ABORT: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      last  <= 1'b1;
      sel   <= 1'b0;
      cnt   <= '0;
      k_q   <= '0;
      rx    <= '0;
      ry    <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == RUN) begin
        last <= pick;
        sel  <= pick;
        cnt  <= '0;
        k_q  <= pick ? bus.k1 : bus.k0;
      end
      // Counter stops at CMAX because RUN is left on that cycle.
      if (state == RUN && nxt == RUN) cnt <= cnt + 1'b1;
      if (state == RUN && bus.core_done) begin
        rx <= bus.core_x;
        ry <= bus.core_y;
      end
    end
  end

  assign busy           = (state != IDLE);
  assign bus.gnt0       = busy && !sel;
  assign bus.gnt1       = busy && sel;
  assign bus.core_start = (state == RUN);
  assign bus.core_k     = k_q;
  assign bus.done0      = (state == DONE) && !sel;
  assign bus.done1      = (state == DONE) && sel;
  assign bus.err        = (state == ABORT);
  assign bus.res_x      = rx;
  assign bus.res_y      = ry;
endmodule

// File: tb/tb_ecc_arbiter.sv
// Directed bench for ecc_arbiter: one default-timeout instance and one
// with TIMEOUT=8 for the abort and coincidence cases.
module tb_ecc_arbiter;
  localparam int KW = 163;
  localparam int PW = 164;

  logic clk;
  logic n_rst;
  int   errors = 0;
  int   checks = 0;

  ecc_arbiter_if #(.KW(KW), .PW(PW)) ia ();
  ecc_arbiter_if #(.KW(KW), .PW(PW)) ib ();

  ecc_arbiter #(.KW(KW), .PW(PW)) dut_a (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (ia)
  );

  ecc_arbiter #(.KW(KW), .PW(PW), .TIMEOUT(8)) dut_b (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int g, d, e, r;
    n_rst = 1'b0;
    ia.req0 = 0; ia.req1 = 0; ia.k0 = '0; ia.k1 = '0;
    ia.core_done = 0; ia.core_x = '0; ia.core_y = '0;
    ib.req0 = 0; ib.req1 = 0; ib.k0 = '0; ib.k1 = '0;
    ib.core_done = 0; ib.core_x = '0; ib.core_y = '0;
    #1;
    chk("rst_gnt0", ia.gnt0, 0);
    chk("rst_gnt1", ia.gnt1, 0);
    chk("rst_start", ia.core_start, 0);
    chk("rst_err", ia.err, 0);
    chk("rst_core_k", ia.core_k, 0);
    chk("rst_res_x", ia.res_x, 0);
    #20 n_rst = 1'b1;
    tick();

    // single request, core_done on the 10th RUN cycle
    ia.k0 = 'h5; ia.core_x = 'hA; ia.core_y = 'hB; ia.req0 = 1;
    g = 0; d = 0; e = 0;
    for (int i = 0; i < 14; i++) begin
      ia.core_done = (i == 10);
      tick();
      g += int'(ia.gnt0); d += int'(ia.done0); e += int'(ia.err);
      if (ia.done0) ia.req0 = 0;
      if (i == 0) begin
        chk("t1_core_k", ia.core_k, 'h5);
        chk("t1_start", ia.core_start, 1);
      end
    end
    ia.core_done = 0;
    chk("t1_gnt_cycles", g, 11);
    chk("t1_done_pulses", d, 1);
    chk("t1_err", e, 0);
    chk("t1_res_x", ia.res_x, 'hA);
    chk("t1_res_y", ia.res_y, 'hB);

    // stray core_done in IDLE
    ia.core_x = 'hFF; ia.core_done = 1;
    tick();
    ia.core_done = 0;
    chk("stray_gnt0", ia.gnt0, 0);
    chk("stray_start", ia.core_start, 0);
    chk("stray_res_x", ia.res_x, 'hA);

    // reset clears results, then tie and fairness
    #2 n_rst = 1'b0;
    #1 chk("rst2_res_x", ia.res_x, 0);
    #2 n_rst = 1'b1;
    ia.k0 = 'h11; ia.k1 = 'h22; ia.req0 = 1; ia.req1 = 1;
    tick();
    chk("tie_gnt0", ia.gnt0, 1);
    chk("tie_gnt1", ia.gnt1, 0);
    chk("tie_core_k", ia.core_k, 'h11);
    ia.core_done = 1;
    tick();
    chk("tie_done0", ia.done0, 1);
    ia.core_done = 0;
    tick();
    chk("tie_idle", {ia.gnt0, ia.gnt1}, 0);
    tick();
    chk("rr_gnt1", ia.gnt1, 1);
    chk("rr_core_k", ia.core_k, 'h22);
    ia.core_done = 1;
    tick();
    chk("rr_done1", ia.done1, 1);
    ia.core_done = 0;
    tick();
    tick();
    chk("rr_gnt0", ia.gnt0, 1);
    ia.core_done = 1;
    tick();
    ia.core_done = 0; ia.req0 = 0; ia.req1 = 0;
    tick();

    // late req1 during requester 0 RUN; req0 dropped mid-RUN
    ia.k0 = 'h33; ia.k1 = 'h44; ia.req0 = 1;
    tick();
    chk("late_gnt0", ia.gnt0, 1);
    ia.req1 = 1; ia.req0 = 0;
    tick();
    tick();
    chk("late_run_gnt0", ia.gnt0, 1);
    chk("late_run_gnt1", ia.gnt1, 0);
    ia.core_done = 1;
    tick();
    chk("late_done0", ia.done0, 1);
    chk("late_done_gnt1", ia.gnt1, 0);
    ia.core_done = 0;
    tick();
    chk("late_idle_gnt1", ia.gnt1, 0);
    tick();
    chk("late_gnt1", ia.gnt1, 1);
    chk("late_core_k", ia.core_k, 'h44);
    ia.core_done = 1;
    tick();
    ia.core_done = 0; ia.req1 = 0;
    tick();

    // reset at RUN cycle 5
    ia.k1 = 'h55; ia.req1 = 1;
    tick();
    repeat (4) tick();
    chk("mid_pre_start", ia.core_start, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_gnt1", ia.gnt1, 0);
    chk("mid_start", ia.core_start, 0);
    repeat (2) tick();
    chk("mid_done1", ia.done1, 0);
    chk("mid_err", ia.err, 0);
    n_rst = 1'b1;
    tick();
    chk("mid_regnt1", ia.gnt1, 1);
    chk("mid_core_k", ia.core_k, 'h55);
    ia.core_done = 1;
    tick();
    ia.core_done = 0; ia.req1 = 0;
    tick();

    // TIMEOUT=8 instance: seed a result, then abort
    ib.req0 = 1; ib.core_x = 'h77; ib.core_y = 'h88; ib.core_done = 1;
    tick();
    tick();
    chk("b_seed_done0", ib.done0, 1);
    chk("b_seed_res_x", ib.res_x, 'h77);
    ib.core_done = 0; ib.req0 = 0;
    tick();
    ib.req1 = 1; ib.core_x = 'hEE; ib.core_y = 'hEE;
    r = 0; e = 0; d = 0;
    for (int i = 0; i < 11; i++) begin
      tick();
      r += int'(ib.core_start); d += int'(ib.done1);
      if (ib.err) begin
        e++;
        chk("to_err_gnt1", ib.gnt1, 1);
        ib.req1 = 0;
      end
    end
    chk("to_run_cycles", r, 8);
    chk("to_err_pulses", e, 1);
    chk("to_done1", d, 0);
    chk("to_res_x", ib.res_x, 'h77);
    chk("to_res_y", ib.res_y, 'h88);

    // core_done on the 8th RUN cycle beats the timeout
    ib.req0 = 1; ib.core_x = 'h99; ib.core_y = 'h9A;
    r = 0; e = 0; d = 0;
    for (int i = 0; i < 11; i++) begin
      ib.core_done = (i == 8);
      tick();
      r += int'(ib.core_start); d += int'(ib.done0); e += int'(ib.err);
      if (ib.done0) ib.req0 = 0;
    end
    ib.core_done = 0;
    chk("co_run_cycles", r, 8);
    chk("co_done0", d, 1);
    chk("co_err", e, 0);
    chk("co_res_x", ib.res_x, 'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ecc_arbiter.md
ECC_ARBITER -- requirements
Module: ecc_arbiter

Interface
REQ-001 Parameter KW, default 163: scalar (private key) width in bits.
REQ-002 Parameter PW, default 164: point coordinate width in bits.
REQ-003 Parameter TIMEOUT, default 4096: maximum RUN cycles before abort; legal range 2..65535.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 req0 / req1  input  1 each  request from requester 0 (public-key generation) and requester 1 (session-key generation); level, held until done or err.
REQ-007 k0 / k1  input  KW each  scalar of requester 0 / 1; sampled only at grant.
REQ-008 gnt0 / gnt1  output  1 each  grant, one-hot or zero.
REQ-009 core_start  output  1  start level to the shared ECC point-multiplier core; high for the whole operation, low otherwise.
REQ-010 core_k  output  KW  latched scalar driven to the core.
REQ-011 core_done  input  1  core completion strobe.
REQ-012 core_x / core_y  input  PW each  core result coordinates, valid when core_done=1.
REQ-013 res_x / res_y  output  PW each  registered result of the last successful operation.
REQ-014 done0 / done1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-015 err  output  1  one-cycle timeout pulse; the errored requester is the one whose gnt is high in the same cycle.

Function
REQ-016 FSM states IDLE, RUN, DONE, ABORT, registered; the next state is combinational.
REQ-017 IDLE, no request: remain in IDLE; core_start=0; gnt0=gnt1=0.
REQ-018 IDLE, exactly one of req0/req1 high: grant that requester; latch its k into the core_k register; clear the cycle counter; go to RUN.
REQ-019 IDLE, both requests high: grant the requester not served last (round-robin pointer last); the other waits.
REQ-020 Pointer last updates to the granted index on the IDLE->RUN transition.
REQ-021 RUN: core_start=1; the granted gnt is high; the counter increments by 1 per cycle.
REQ-022 RUN with core_done=1: latch core_x/core_y into res_x/res_y; go to DONE.
REQ-023 RUN with core_done=0 and counter==TIMEOUT-1: go to ABORT. The RUN dwell is therefore at most TIMEOUT cycles.
REQ-024 core_done and the timeout condition in the same cycle: core_done wins, giving a DONE transition and no err.
REQ-025 DONE: exactly one cycle; core_start=0; the granted gnt stays high; done0 or done1 pulses for the granted requester; go to IDLE.
REQ-026 ABORT: exactly one cycle; core_start=0; the granted gnt stays high; err=1; res_x/res_y unchanged; go to IDLE.
REQ-027 Dropping the granted req during RUN is ignored: the operation completes or aborts normally.
REQ-028 A new req from either requester during RUN, DONE or ABORT is not served until the next IDLE cycle.
REQ-029 Minimum turnaround is RUN->DONE->IDLE->RUN, so at least one IDLE cycle separates successive grants.
REQ-030 core_done while not in RUN is ignored.
REQ-031 res_x/res_y hold their value until the next DONE transition.
REQ-032 The counter width is the smallest that holds TIMEOUT-1; the counter never wraps.

Reset
REQ-033 On n_rst=0, immediately and asynchronously: state=IDLE, last=1 (requester 0 wins the first tie), counter=0, core_k=0, res_x=res_y=0.
REQ-034 While n_rst=0: core_start, gnt0, gnt1, done0, done1 and err are all 0.
REQ-035 Reset asserted mid-RUN: the operation is abandoned; no done or err pulse is produced.
REQ-036 After reset release: the first rising edge with a request pending grants per REQ-018/REQ-019.

Verification
REQ-037 Single request: req0=1, k0=0x5; core_done at the 10th RUN cycle with core_x=0xA, core_y=0xB -> gnt0=1 for 11 cycles, core_k=0x5, done0 pulses once, res_x=0xA, res_y=0xB, err=0.
REQ-038 Tie and fairness: req0=req1=1 held after reset -> first grant gnt0; after done0, the next grant is gnt1; then gnt0 again.
REQ-039 Timeout: TIMEOUT=8, req1=1, core_done never asserted -> 8 RUN cycles, then err=1 with gnt1=1; done1 stays 0; res_x/res_y unchanged.
REQ-040 Coincidence: TIMEOUT=8, core_done=1 on the 8th RUN cycle -> DONE taken, done pulse, no err.
REQ-041 Reset mid-RUN: n_rst low at RUN cycle 5 -> all outputs 0 at once; no done/err; after release with req1 pending, gnt1 granted on the next edge.
REQ-042 Stray and late inputs: core_done pulsed in IDLE -> no state change; req1 raised during RUN of requester 0 -> served only after the DONE and IDLE cycles.
